// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline stall/flush sequencer and its pipeline registers
package pipe_ctrl_pkg;
    localparam int DEF_REG_AW      = 5;
    localparam int DEF_MEM_TIMEOUT = 16;
    localparam int DEF_CNT_W       = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HOLD     = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_we;
        logic memwb_we;
    } ctrl_t;

    // Stall keeps the back half moving and drains a bubble into EX; freeze halts everything.
    localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
endpackage

// File: rtl/hazard_need_calc.sv
// hazard_need_calc: number of stall cycles the ID instruction needs before forwarding can serve it
module hazard_need_calc
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              ctrl_branch,
    input  logic              idex_mem_read,
    input  logic              idex_reg_wr,
    input  logic [REG_AW-1:0] idex_dst,
    input  logic              exmem_mem_read,
    input  logic [REG_AW-1:0] exmem_dst,
    output logic [1:0]        need
);
    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = (idex_dst != '0) && ((idex_dst == ifid_rs) || (ifid_uses_rt && (idex_dst == ifid_rt)));
    assign mem_hit = (exmem_dst != '0) && ((exmem_dst == ifid_rs) || (ifid_uses_rt && (exmem_dst == ifid_rt)));

    // Branches compare in ID, so they also wait on ALU results and on loads one stage further on.
    always_comb begin
        need = ctrl_branch ?
               ((idex_mem_read && ex_hit) ? 2'd2 :
                ((idex_reg_wr && ex_hit) || (exmem_mem_read && mem_hit)) ? 2'd1 : 2'd0) :
               ((idex_mem_read && ex_hit) ? 2'd1 : 2'd0);
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall, flush and freeze sequencing for the 5-stage pipeline
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = DEF_REG_AW,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              ctrl_branch,
    input  logic              branch_taken,
    input  logic              idex_mem_read,
    input  logic              idex_reg_wr,
    input  logic [REG_AW-1:0] idex_dst,
    input  logic              exmem_mem_read,
    input  logic [REG_AW-1:0] exmem_dst,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cycles
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    state_e            saved_q, saved_d;
    state_e            eff;
    logic [1:0]        hold_q, hold_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [1:0]        need;
    ctrl_t             ctrl;
    ctrl_t             run_ctrl;
    ctrl_t             out_ctrl;

    hazard_need_calc #(.REG_AW(REG_AW)) u_need (
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .ifid_uses_rt   (ifid_uses_rt),
        .ctrl_branch    (ctrl_branch),
        .idex_mem_read  (idex_mem_read),
        .idex_reg_wr    (idex_reg_wr),
        .idex_dst       (idex_dst),
        .exmem_mem_read (exmem_mem_read),
        .exmem_dst      (exmem_dst),
        .need           (need)
    );

    always_comb begin
        state_d   = state_q;
        saved_d   = saved_q;
        hold_d    = hold_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        ctrl      = CTRL_FREEZE;
        run_ctrl  = CTRL_STALL;
        if (need == 2'd0) begin
            run_ctrl            = CTRL_RUN;
            run_ctrl.ifid_flush = ctrl_branch & branch_taken;
        end
        eff = (state_q == MEM_WAIT) ? saved_q : state_q;
        if (state_q != MEM_WAIT && dmem_req && !dmem_ready) begin
            saved_d = state_q;
            state_d = MEM_WAIT;
            wait_d  = WW'(1);
        end else if (state_q == MEM_WAIT && !dmem_ready) begin
            if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
                timeout_d = 1'b1;
                state_d   = saved_q;
                wait_d    = '0;
            end else begin
                wait_d = wait_q + WW'(1);
            end
        end else begin
            // Completing a wait replays the saved state's own behaviour in the same cycle.
            wait_d = '0;
            if (eff == HOLD) begin
                ctrl    = CTRL_STALL;
                hold_d  = hold_q - 2'd1;
                state_d = (hold_d == 2'd0) ? RUN : HOLD;
            end else begin
                ctrl    = run_ctrl;
                state_d = (need == 2'd2) ? HOLD : RUN;
                hold_d  = (need == 2'd2) ? 2'd1 : hold_q;
            end
        end
        stall_d = (!ctrl.pc_we && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            saved_q   <= RUN;
            hold_q    <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            hold_q    <= hold_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

    assign out_ctrl     = rst_n ? ctrl : CTRL_RESET;
    assign pc_we        = out_ctrl.pc_we;
    assign ifid_we      = out_ctrl.ifid_we;
    assign ifid_flush   = out_ctrl.ifid_flush;
    assign idex_bubble  = out_ctrl.idex_bubble;
    assign exmem_we     = out_ctrl.exmem_we;
    assign memwb_we     = out_ctrl.memwb_we;
    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;
endmodule
